pipe_chain: RTL
===============

Name: pipe_chain

Overview:
- Parametrised in-order pipeline skeleton: a chain of DEPTH payload registers with per-stage valid bits, per-stage hold, and kill-younger flush.
- Successor to the fixed five-stage enable/clear register chain driven by a global stall/flush hazard unit; replaces it with local stall propagation, so empty stages (bubbles) collapse instead of stalling the whole pipe.
- Sits between instruction fetch and writeback; instantiated once per payload bundle.

Parameters:
WIDTH, 32, payload bits per stage
DEPTH, 5, number of stages (>=2); stage 0 youngest (entry), stage DEPTH-1 oldest (exit)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  entry offers payload to stage 0
in_data  input  WIDTH  entry payload
in_ready  output  1  stage 0 accepts this cycle
hold_i  input  DEPTH  bit i: stage i keeps its entry (multi-cycle op, e.g. divide)
flush_i  input  DEPTH  bit k: kill stages 0..k this cycle
out_valid  output  1  stage DEPTH-1 offers payload
out_data  output  WIDTH  stage DEPTH-1 payload
out_ready  input  1  consumer accepts
stage_valid  output  DEPTH  registered valid bits
stage_data  output  DEPTH*WIDTH  stage i at bits [i*WIDTH +: WIDTH]
occupancy  output  $clog2(DEPTH+1)  popcount of stage_valid
retire_cnt  output  32  completed out transfers

Behaviour:
- Reset (async, immediate): stage_valid=0, stage_data=0, retire_cnt=0. Outputs follow: out_valid=0, in_ready=1, occupancy=0.
- Kill mask: f[i] = OR of flush_i[j] for j>=i. So flush_i[k] sets f[0..k].
- Move-out condition for stage i: move[i] = valid[i] & ~hold_i[i] & ~f[i] & acc[i+1].
  - acc[DEPTH] = out_ready.
  - acc[i] = ~valid[i] | move[i] for i<DEPTH.
- in_ready = acc[0].
- out_valid = valid[DEPTH-1] & ~hold_i[DEPTH-1] & ~f[DEPTH-1]; out_data = stage DEPTH-1 data.
- Combinational path out_ready -> in_ready through DEPTH stages is intended; no registered skid.
- Next state of valid[i] (evaluated in this priority order):
  - f[i]=1: valid[i] becomes 0. Hold is ignored, and any entry arriving from stage i-1 is also dropped, because f[i-1] is set whenever f[i] is.
  - Else if an entry arrives (move[i-1], or in_valid & in_ready for i=0): valid[i]=1 and data[i] loads the incoming payload.
  - Else if move[i]: valid[i]=0.
  - Else: valid[i] unchanged.
- Any flush_i bit set: the stage-0 entry offer is discarded. in_ready may still read 1 but the payload is not loaded.
- Data registers load only on entry; flush and drain clear valid only, never data.
- Order preserved: no overtaking. One entry per stage. Throughput 1 entry/cycle with no hold and out_ready=1.
- Latency: entry accepted at edge n gives out_valid=1 after edge n+DEPTH-1, given no holds and no flushes.
- retire_cnt increments by 1 on each edge where out_valid & out_ready; wraps 2^32-1 -> 0.
- A flush on stage DEPTH-1 suppresses out_valid that cycle, so no transfer occurs and retire_cnt does not increment.
- hold_i on an empty stage has no effect.
- flush_i and hold_i on the same stage: flush wins.
- Reset asserted mid-stream drops all entries; the first edge after release behaves as from empty.

Test Plan:
1. Reset: assert rst mid-cycle with 3 valid stages -> stage_valid=0 immediately, in_ready=1, retire_cnt=0, occupancy=0.
2. Stream (DEPTH=5): in_valid=1, data 1,2,3,... from edge 0, out_ready=1 -> out_valid first high after edge 4 with out_data=1; then 2,3,... every cycle; retire_cnt=10 after 10 transfers.
3. Back-pressure and bubble collapse: out_ready=0, in_valid pattern 1,0,1,0,... with data 0xA0.. -> five entries accepted; stage_valid=5'b11111; in_ready=0 until out_ready=1, then it returns the same cycle; output order 0xA0..0xA4.
4. Hold: pipe full with 1..5 (5 at stage 4). Hold stage 2 (holding 3) for 3 cycles, out_ready=1, in_valid=0 -> 5,4 retire; stages 3,4 empty; stages 0-1 stay at 1,2. Release -> 3,2,1 emerge in order; retire_cnt=5.
5. Flush: stages hold E(4),D,C,B,A(0), out_ready=0, in_valid=1 data 0xFF, flush_i=5'b00100 one cycle -> stage_valid=5'b11000, occupancy=2, 0xFF not loaded. Next: flush_i=5'b10000 with out_ready=1 -> out_valid=0, retire_cnt unchanged, stage_valid=0.
6. Wrap and precedence: force retire_cnt=32'hFFFF_FFFF (via 2^32-1 transfers or a bench backdoor) then one transfer -> 0. hold_i[3]=flush_i[3]=1 on a valid stage 3 -> stage 3 cleared.

Source files
------------

// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_chain
//  Description : In-order pipeline skeleton. A chain of DEPTH payload
//                registers with per-stage valid bits, per-stage hold and
//                kill-younger flush. Stalls propagate locally, so empty
//                stages (bubbles) collapse instead of stalling the pipe.
//                Stage 0 is the youngest (entry), stage DEPTH-1 the oldest
//                (exit).
//  Ports       :
//    clk          rising-edge clock
//    rst          asynchronous active-high reset
//    in_valid     entry offers payload to stage 0
//    in_data      entry payload
//    in_ready     stage 0 accepts this cycle
//    hold_i       bit i: stage i keeps its entry
//    flush_i      bit k: kill stages 0..k this cycle
//    out_valid    stage DEPTH-1 offers payload
//    out_data     stage DEPTH-1 payload
//    out_ready    consumer accepts
//    stage_valid  registered valid bits
//    stage_data   stage i payload at [i*WIDTH +: WIDTH]
//    occupancy    number of valid stages
//    retire_cnt   completed output transfers (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic [DEPTH-1:0]           hold_i,
  input  logic [DEPTH-1:0]           flush_i,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [DEPTH*WIDTH-1:0]     stage_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                retire_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [31:0]                 retire_cnt_q;
  logic [31:0]                 retire_cnt_d;

  logic [DEPTH-1:0]            kill;      // stage is killed this cycle
  logic [DEPTH-1:0]            move;      // stage hands its entry onward
  logic [DEPTH:0]              acc;       // stage can take a new entry
  logic [DEPTH-1:0]            enter;     // an entry arrives at stage i
  logic [DEPTH-1:0][WIDTH-1:0] incoming;  // payload offered to stage i

  // Kill mask: a flush on stage k also kills every younger stage, so the
  // mask is a suffix-OR running from the oldest stage down to stage 0.
  // Acceptance ripples from the consumer back to the entry; this is the
  // intended combinational out_ready -> in_ready path.
  always_comb begin
    kill = '0;
    move = '0;
    acc  = '0;
    kill[DEPTH-1] = flush_i[DEPTH-1];
    for (int i = DEPTH-2; i >= 0; i--) begin
      kill[i] = flush_i[i] | kill[i+1];
    end
    acc[DEPTH] = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      move[i] = valid_q[i] & ~hold_i[i] & ~kill[i] & acc[i+1];
      acc[i]  = ~valid_q[i] | move[i];
    end
  end

  // Any flush sets kill[0], which discards the entry offer even though
  // in_ready may still read high.
  always_comb begin
    enter       = '0;
    incoming    = '0;
    enter[0]    = in_valid & acc[0] & ~kill[0];
    incoming[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      enter[i]    = move[i-1];
      incoming[i] = data_q[i-1];
    end
  end

  // Next state: kill beats arrival beats departure. Data only ever loads
  // on arrival; kill and drain touch the valid bit alone.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
      end else if (enter[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = incoming[i];
      end else if (move[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (out_valid && out_ready) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      data_q       <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(valid_q[i]);
    end
  end

  assign in_ready    = acc[0];
  assign out_valid   = valid_q[DEPTH-1] & ~hold_i[DEPTH-1] & ~kill[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign stage_valid = valid_q;
  assign stage_data  = data_q;
  assign retire_cnt  = retire_cnt_q;

endmodule
`default_nettype wire
